// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and data-memory wait
// handshakes for a 5-stage pipeline, plus a saturating hazard event counter.
module hazard_stall_controller #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned LD_STALL    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic               ex_valid,
  input  logic               ex_branch_take,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               mem_valid,
  input  logic               dmem_ack,
  output logic               pc_en,
  output logic               pc_sel_branch,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_bubble,
  output logic               exmem_en,
  output logic               dmem_req,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   hazard_count
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDSTALL  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ST_W-1:0]  st_cnt, st_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             ret_ld, ret_ld_nxt;
  logic             hz_inc;
  logic             err_set;
  logic             run_eval;
  logic             ld_eval;

  // Instruction field decode
  logic id_branch, ex_load, ex_branch, mem_op;
  logic load_use, mem_stall, br_take;
  logic unused_bits;

  assign id_branch = (id_instr[27:26] == 2'b10);
  assign ex_load   = (ex_instr[27:26] == 2'b01) & ex_instr[20];
  assign ex_branch = (ex_instr[27:26] == 2'b10);
  assign mem_op    = (mem_instr[27:26] == 2'b01);
  assign load_use  = ex_valid & ex_load & id_valid & ~id_branch &
                     ((ex_instr[15:12] == id_instr[19:16]) |
                      (ex_instr[15:12] == id_instr[3:0]));
  assign mem_stall = mem_valid & mem_op & ~dmem_ack;
  assign br_take   = ex_valid & ex_branch & ex_branch_take;
  assign unused_bits = ^{id_instr, ex_instr, mem_instr};

  // Next state, counter updates and stage controls
  always_comb begin
    state_nxt     = state;
    st_cnt_nxt    = st_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    ret_ld_nxt    = ret_ld;
    hz_inc        = 1'b0;
    err_set       = 1'b0;
    run_eval      = 1'b0;
    ld_eval       = 1'b0;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_bubble   = 1'b0;
    exmem_en      = 1'b1;
    dmem_req      = 1'b0;

    if (!reset) begin
      case (state)
        RUN: begin
          dmem_req = mem_valid & mem_op;
          if (mem_stall) begin
            state_nxt   = MEM_WAIT;
            tmo_cnt_nxt = '0;
            ret_ld_nxt  = 1'b0;
          end else begin
            run_eval = 1'b1;
          end
        end
        LDSTALL: begin
          dmem_req = mem_valid & mem_op;
          if (mem_stall) begin
            state_nxt   = MEM_WAIT;
            tmo_cnt_nxt = '0;
            ret_ld_nxt  = 1'b1;
          end else begin
            ld_eval    = 1'b1;
            st_cnt_nxt = st_cnt - ST_W'(1);
            if (st_cnt <= ST_W'(1)) begin
              state_nxt = RUN;
            end
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            // Access completes; the frozen hazard context is evaluated now
            if (ret_ld) begin
              ld_eval   = 1'b1;
              state_nxt = LDSTALL;
            end else begin
              run_eval  = 1'b1;
              state_nxt = RUN;
            end
          end else begin
            if (tmo_cnt != TMO_W'(MEM_TIMEOUT)) begin
              tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
            err_set = (tmo_cnt_nxt == TMO_W'(MEM_TIMEOUT));
          end
        end
        default: state_nxt = RUN;
      endcase

      if (mem_stall || (state == MEM_WAIT && !dmem_ack)) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end

      if (run_eval) begin
        if (br_take) begin
          pc_sel_branch = 1'b1;
          ifid_flush    = 1'b1;
          idex_bubble   = 1'b1;
          hz_inc        = 1'b1;
        end else if (load_use) begin
          ld_eval = 1'b1;
          hz_inc  = 1'b1;
          if (LD_STALL > 1) begin
            state_nxt  = LDSTALL;
            st_cnt_nxt = ST_W'(LD_STALL - 1);
          end
        end
      end

      if (ld_eval) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      st_cnt       <= '0;
      tmo_cnt      <= '0;
      ret_ld       <= 1'b0;
      err_timeout  <= 1'b0;
      hazard_count <= '0;
    end else begin
      state   <= state_nxt;
      st_cnt  <= st_cnt_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      ret_ld  <= ret_ld_nxt;
      if (err_set) begin
        err_timeout <= 1'b1;
      end
      if (hz_inc && (hazard_count != {CNT_W{1'b1}})) begin
        hazard_count <= hazard_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: two instances (LD_STALL=1/MEM_TIMEOUT=8 and
// LD_STALL=3) share stimulus; stage controls are compared as one packed byte.
module tb_hazard_stall_controller;

  localparam logic [31:0] LDR3    = 32'h0410_3000;  // LDR r3
  localparam logic [31:0] STR3    = 32'h0400_3000;  // STR r3
  localparam logic [31:0] ADD_RN  = 32'h0003_5001;  // ADD r5,r3,r1
  localparam logic [31:0] ADD_RM  = 32'h0001_5003;  // ADD r5,r1,r3
  localparam logic [31:0] ADD_IND = 32'h0008_7009;  // ADD r7,r8,r9
  localparam logic [31:0] BR_RN3  = 32'h0803_0000;  // branch, rn field = 3
  localparam logic [31:0] BR      = 32'h0800_3000;  // branch

  // {pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, dmem_req}
  localparam logic [7:0] O_RUN   = 8'hAA;
  localparam logic [7:0] O_LDST  = 8'h0E;
  localparam logic [7:0] O_BR    = 8'hFE;
  localparam logic [7:0] O_FRZ   = 8'h01;
  localparam logic [7:0] O_ACK   = 8'hAB;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr, ex_instr, mem_instr;
  logic        id_valid, ex_valid, ex_branch_take, mem_valid, dmem_ack;

  logic        a_pc_en, a_pc_sel_branch, a_ifid_en, a_ifid_flush;
  logic        a_idex_en, a_idex_bubble, a_exmem_en, a_dmem_req, a_err;
  logic [15:0] a_hc;
  logic        b_pc_en, b_pc_sel_branch, b_ifid_en, b_ifid_flush;
  logic        b_idex_en, b_idex_bubble, b_exmem_en, b_dmem_req, b_err;
  logic [15:0] b_hc;
  logic [7:0]  a_out, b_out;

  int checks   = 0;
  int failures = 0;

  hazard_stall_controller #(.INSTR_W(32), .LD_STALL(1), .MEM_TIMEOUT(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset),
    .id_instr(id_instr), .id_valid(id_valid),
    .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_branch_take(ex_branch_take),
    .mem_instr(mem_instr), .mem_valid(mem_valid), .dmem_ack(dmem_ack),
    .pc_en(a_pc_en), .pc_sel_branch(a_pc_sel_branch), .ifid_en(a_ifid_en),
    .ifid_flush(a_ifid_flush), .idex_en(a_idex_en), .idex_bubble(a_idex_bubble),
    .exmem_en(a_exmem_en), .dmem_req(a_dmem_req), .err_timeout(a_err), .hazard_count(a_hc)
  );

  hazard_stall_controller #(.INSTR_W(32), .LD_STALL(3), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset),
    .id_instr(id_instr), .id_valid(id_valid),
    .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_branch_take(ex_branch_take),
    .mem_instr(mem_instr), .mem_valid(mem_valid), .dmem_ack(dmem_ack),
    .pc_en(b_pc_en), .pc_sel_branch(b_pc_sel_branch), .ifid_en(b_ifid_en),
    .ifid_flush(b_ifid_flush), .idex_en(b_idex_en), .idex_bubble(b_idex_bubble),
    .exmem_en(b_exmem_en), .dmem_req(b_dmem_req), .err_timeout(b_err), .hazard_count(b_hc)
  );

  assign a_out = {a_pc_en, a_pc_sel_branch, a_ifid_en, a_ifid_flush,
                  a_idex_en, a_idex_bubble, a_exmem_en, a_dmem_req};
  assign b_out = {b_pc_en, b_pc_sel_branch, b_ifid_en, b_ifid_flush,
                  b_idex_en, b_idex_bubble, b_exmem_en, b_dmem_req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs and move to the sampling point (falling edge)
  task automatic cyc(input logic iv, input logic [31:0] ii, input logic ev, input logic [31:0] ei,
                     input logic tk, input logic mv, input logic [31:0] mi, input logic ack);
    id_valid       = iv;
    id_instr       = ii;
    ex_valid       = ev;
    ex_instr       = ei;
    ex_branch_take = tk;
    mem_valid      = mv;
    mem_instr      = mi;
    dmem_ack       = ack;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    @(negedge clk);
    check("rst_a_out", 32'(a_out), 32'(O_RUN));
    check("rst_b_out", 32'(b_out), 32'(O_RUN));
    check("rst_a_hc", 32'(a_hc), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    tick();
    reset = 1'b0;

    // Load-use on rn: A stalls one cycle, B holds three
    cyc(1'b1, ADD_RN, 1'b1, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu1_a_out", 32'(a_out), 32'(O_LDST));
    check("lu1_b_out", 32'(b_out), 32'(O_LDST));
    check("lu1_a_hc", 32'(a_hc), 32'd0);
    tick();
    cyc(1'b1, ADD_RN, 1'b0, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu2_a_out", 32'(a_out), 32'(O_RUN));
    check("lu2_a_hc", 32'(a_hc), 32'd1);
    check("lu2_b_out", 32'(b_out), 32'(O_LDST));
    tick();
    @(negedge clk);
    check("lu3_b_out", 32'(b_out), 32'(O_LDST));
    tick();
    @(negedge clk);
    check("lu4_b_out", 32'(b_out), 32'(O_RUN));
    check("lu4_b_hc", 32'(b_hc), 32'd1);
    tick();

    // Load-use detection boundaries on instance A
    cyc(1'b1, ADD_RM, 1'b1, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu_rm_out", 32'(a_out), 32'(O_LDST));
    tick();
    cyc(1'b1, BR_RN3, 1'b1, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu_idbr_out", 32'(a_out), 32'(O_RUN));
    check("lu_rm_hc", 32'(a_hc), 32'd2);
    tick();
    cyc(1'b1, ADD_RN, 1'b0, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu_exinv_out", 32'(a_out), 32'(O_RUN));
    tick();
    cyc(1'b1, ADD_IND, 1'b1, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu_nodep_out", 32'(a_out), 32'(O_RUN));
    tick();
    cyc(1'b1, ADD_RN, 1'b1, STR3, 1'b0, 1'b0, 32'h0, 1'b0);
    check("lu_str_out", 32'(a_out), 32'(O_RUN));
    tick();

    // Taken branch flushes with a dependent instruction in ID
    cyc(1'b1, ADD_RN, 1'b1, BR, 1'b1, 1'b0, 32'h0, 1'b0);
    check("br_out", 32'(a_out), 32'(O_BR));
    tick();
    cyc(1'b1, ADD_RN, 1'b0, BR, 1'b0, 1'b0, 32'h0, 1'b0);
    check("br_after_out", 32'(a_out), 32'(O_RUN));
    check("br_hc", 32'(a_hc), 32'd3);
    tick();
    cyc(1'b1, ADD_RN, 1'b1, BR, 1'b0, 1'b0, 32'h0, 1'b0);
    check("br_nt_out", 32'(a_out), 32'(O_RUN));
    tick();
    idle();
    check("br_nt_hc", 32'(a_hc), 32'd3);
    tick();

    // Reset while B sits in LDSTALL
    cyc(1'b1, ADD_RN, 1'b1, LDR3, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    check("ldst_b_pre", 32'(b_out), 32'(O_LDST));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("ldst_rst_b_out", 32'(b_out), 32'(O_RUN));
    check("ldst_rst_b_hc", 32'(b_hc), 32'd0);
    check("ldst_rst_a_hc", 32'(a_hc), 32'd0);
    tick();

    // Store waits four cycles, ack on the fifth
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b0);
      check($sformatf("mw_frz%0d", k), 32'(a_out), 32'(O_FRZ));
      tick();
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b1);
    check("mw_ack_out", 32'(a_out), 32'(O_ACK));
    tick();
    idle();
    check("mw_after_out", 32'(a_out), 32'(O_RUN));
    tick();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b1);
    check("mw_0wait_out", 32'(a_out), 32'(O_ACK));
    check("mw_hc", 32'(a_hc), 32'd0);
    tick();

    // Timeout: err_timeout rises after eight MEM_WAIT cycles and sticks
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b0);
    check("tmo_run_out", 32'(a_out), 32'(O_FRZ));
    tick();
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b0);
      check($sformatf("tmo_out%0d", k), 32'(a_out), 32'(O_FRZ));
      check($sformatf("tmo_err%0d", k), 32'(a_err), (k >= 9) ? 32'd1 : 32'd0);
      tick();
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b1);
    check("tmo_ack_out", 32'(a_out), 32'(O_ACK));
    check("tmo_ack_err", 32'(a_err), 32'd1);
    tick();
    idle();
    check("tmo_after_out", 32'(a_out), 32'(O_RUN));
    check("tmo_after_err", 32'(a_err), 32'd1);
    tick();

    // Reset while A sits in MEM_WAIT
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b0);
    tick();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, STR3, 1'b0);
    check("mwr_pre_out", 32'(a_out), 32'(O_FRZ));
    reset = 1'b1;
    @(negedge clk);
    check("mwr_in_rst_out", 32'(a_out), 32'(O_RUN));
    tick();
    reset = 1'b0;
    idle();
    check("mwr_out", 32'(a_out), 32'(O_RUN));
    check("mwr_err", 32'(a_err), 32'd0);
    check("mwr_hc", 32'(a_hc), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
